// File: rtl/amm_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : amm_cmd_scheduler
// Brief    : Accepts one transaction at a time over valid/ready and drives it
//            onto an Avalon-MM master port. Writes become multi-beat bursts
//            with per-beat byteenable; reads are gated by read-return credit.
//            Optional burst statistics: define AMM_SCHED_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module amm_cmd_scheduler #(
  parameter int AMM_DATA_W    = 128,
  parameter int AMM_ADDR_W    = 12,
  parameter int AMM_BURST_W   = 11,
  parameter int BYTE_PER_WORD = AMM_DATA_W / 8,
  parameter int BYTE_ADDR_W   = $clog2(BYTE_PER_WORD),
  parameter int ADDR_W        = AMM_ADDR_W - BYTE_ADDR_W,
  parameter int MAX_RD_WORDS  = 16,
  parameter int PEND_W        = $clog2(MAX_RD_WORDS + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     op_valid_i,
  output logic                     op_ready_o,
  input  logic                     op_type_i,
  input  logic [ADDR_W-1:0]        op_word_addr_i,
  input  logic [AMM_BURST_W-1:0]   op_burst_i,
  input  logic [BYTE_ADDR_W-1:0]   op_start_off_i,
  input  logic [BYTE_ADDR_W-1:0]   op_end_off_i,
  input  logic [AMM_DATA_W-1:0]    wr_data_i,
  output logic                     wr_data_req_o,
  output logic [AMM_ADDR_W-1:0]    amm_address_o,
  output logic                     amm_read_o,
  output logic                     amm_write_o,
  output logic [AMM_BURST_W-1:0]   amm_burstcount_o,
  output logic [BYTE_PER_WORD-1:0] amm_byteenable_o,
  output logic [AMM_DATA_W-1:0]    amm_writedata_o,
  input  logic                     amm_waitrequest_i,
  input  logic                     amm_readdatavalid_i,
  output logic [PEND_W-1:0]        rd_pend_o,
`ifdef AMM_SCHED_STATS_EN
  input  logic                     stats_clr_i,
  output logic [31:0]              wr_burst_cnt_o,
  output logic [31:0]              rd_burst_cnt_o,
`endif
  output logic                     busy_o
);

  localparam int SUM_W = ((AMM_BURST_W > PEND_W) ? AMM_BURST_W : PEND_W) + 1;
  localparam logic [BYTE_ADDR_W-1:0]   c_top_byte = BYTE_ADDR_W'(BYTE_PER_WORD - 1);
  localparam logic [BYTE_PER_WORD-1:0] c_be_ones  = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  state_t                   r_state;
  logic [AMM_BURST_W-1:0]   r_beat;
  logic [BYTE_ADDR_W-1:0]   r_start_off;
  logic [BYTE_ADDR_W-1:0]   r_end_off;
  logic [PEND_W-1:0]        r_rd_pend;

  logic                     w_op_hs;
  logic [AMM_BURST_W-1:0]   w_op_burst;
  logic                     w_wr_acc;
  logic                     w_rd_acc;
  logic                     w_last_beat;
  logic [AMM_BURST_W-1:0]   w_next_beat;
  logic                     w_next_last;
  logic                     w_rdv_dec;
  logic [PEND_W-1:0]        w_pend_dec;
  logic                     w_rd_fit;
  logic [SUM_W-1:0]         w_pend_nxt;

  // Byte mask of one beat: first beat trims below start offset, last beat
  // trims above end offset; a single beat gets both trims (0 if inverted).
  function automatic logic [BYTE_PER_WORD-1:0] f_beat_be(
    input logic                   first,
    input logic                   last,
    input logic [BYTE_ADDR_W-1:0] s_off,
    input logic [BYTE_ADDR_W-1:0] e_off
  );
    logic [BYTE_PER_WORD-1:0] m;
    m = c_be_ones;
    if (first) m = m & (c_be_ones << s_off);
    if (last)  m = m & (c_be_ones >> (c_top_byte - e_off));
    return m;
  endfunction

  // Handshake, beat accept and read-credit evaluation
  always_comb begin
    w_op_hs     = op_valid_i && op_ready_o;
    w_op_burst  = (op_burst_i == '0) ? AMM_BURST_W'(1) : op_burst_i;
    w_wr_acc    = amm_write_o && !amm_waitrequest_i;
    w_rd_acc    = amm_read_o && !amm_waitrequest_i;
    w_last_beat = (r_beat == (amm_burstcount_o - AMM_BURST_W'(1)));
    w_next_beat = r_beat + AMM_BURST_W'(1);
    w_next_last = (w_next_beat == (amm_burstcount_o - AMM_BURST_W'(1)));
    // Return data arriving this cycle already frees credit for the check.
    w_rdv_dec   = amm_readdatavalid_i && (r_rd_pend != '0);
    w_pend_dec  = r_rd_pend - PEND_W'(w_rdv_dec);
    w_rd_fit    = (SUM_W'(w_pend_dec) + SUM_W'(amm_burstcount_o)) <= SUM_W'(MAX_RD_WORDS);
    w_pend_nxt  = SUM_W'(w_pend_dec) + (w_rd_acc ? SUM_W'(amm_burstcount_o) : SUM_W'(0));
  end

  assign wr_data_req_o   = w_wr_acc;
  assign amm_writedata_o = wr_data_i;
  assign rd_pend_o       = r_rd_pend;
  assign busy_o          = (r_state != ST_IDLE) || (r_rd_pend != '0);

  // Command FSM with registered AMM command outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state          <= ST_IDLE;
      op_ready_o       <= 1'b0;
      amm_read_o       <= 1'b0;
      amm_write_o      <= 1'b0;
      amm_address_o    <= '0;
      amm_burstcount_o <= '0;
      amm_byteenable_o <= '0;
      r_beat           <= '0;
      r_start_off      <= '0;
      r_end_off        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          op_ready_o <= 1'b1;
          if (w_op_hs) begin
            op_ready_o       <= 1'b0;
            amm_address_o    <= {op_word_addr_i, {BYTE_ADDR_W{1'b0}}};
            amm_burstcount_o <= w_op_burst;
            r_start_off      <= op_start_off_i;
            r_end_off        <= op_end_off_i;
            r_beat           <= '0;
            if (op_type_i) begin
              r_state          <= ST_RD;
              amm_byteenable_o <= c_be_ones;
            end else begin
              r_state          <= ST_WR;
              amm_write_o      <= 1'b1;
              amm_byteenable_o <= f_beat_be(1'b1, w_op_burst == AMM_BURST_W'(1),
                                            op_start_off_i, op_end_off_i);
            end
          end
        end
        ST_WR: begin
          if (w_wr_acc) begin
            if (w_last_beat) begin
              amm_write_o <= 1'b0;
              op_ready_o  <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_beat           <= w_next_beat;
              amm_byteenable_o <= f_beat_be(1'b0, w_next_last, r_start_off, r_end_off);
            end
          end
        end
        ST_RD: begin
          if (!amm_read_o) begin
            if (w_rd_fit) amm_read_o <= 1'b1;
          end else if (!amm_waitrequest_i) begin
            amm_read_o <= 1'b0;
            op_ready_o <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outstanding read words: add burst on accept, drop one per returned word
  always_ff @(posedge clk_i) begin
    if (rst_i) r_rd_pend <= '0;
    else       r_rd_pend <= PEND_W'(w_pend_nxt);
  end

`ifdef AMM_SCHED_STATS_EN
  // Burst statistics; clear wins over a same-cycle increment
  always_ff @(posedge clk_i) begin
    if (rst_i || stats_clr_i) begin
      wr_burst_cnt_o <= '0;
      rd_burst_cnt_o <= '0;
    end else begin
      if (w_wr_acc && w_last_beat) wr_burst_cnt_o <= wr_burst_cnt_o + 32'd1;
      if (w_rd_acc)                rd_burst_cnt_o <= rd_burst_cnt_o + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/amm_cmd_scheduler.md
Name: amm_cmd_scheduler

Overview:
Takes one transaction at a time from the test control block over a valid/ready handshake and drives it onto the Avalon-MM master interface of the memory under test. Write transactions become multi-beat write bursts with per-beat byteenable derived from the start/end byte offsets. Read transactions are issued only while enough read-return credit exists. The block sits between the control block and the AMM port of the memory checker.

Parameters:
AMM_DATA_W, 128, AMM data width in bits
AMM_ADDR_W, 12, AMM byte-address width
AMM_BURST_W, 11, AMM burstcount width
BYTE_PER_WORD, AMM_DATA_W/8, bytes per data word
BYTE_ADDR_W, $clog2(BYTE_PER_WORD), byte-offset width
ADDR_W, AMM_ADDR_W-BYTE_ADDR_W, word-address width
MAX_RD_WORDS, 16, maximum read words outstanding (not yet returned)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
op_valid_i  in  1  transaction valid
op_ready_o  out  1  scheduler can accept a transaction
op_type_i  in  1  0 = write, 1 = read
op_word_addr_i  in  ADDR_W  start word address
op_burst_i  in  AMM_BURST_W  burst length in words; 0 is treated as 1
op_start_off_i  in  BYTE_ADDR_W  first valid byte in the first word
op_end_off_i  in  BYTE_ADDR_W  last valid byte in the last word (inclusive)
wr_data_i  in  AMM_DATA_W  write data for the current beat, valid combinationally
wr_data_req_o  out  1  pulses when a write beat is accepted (data consumed)
amm_address_o  out  AMM_ADDR_W  byte address = {word_addr, BYTE_ADDR_W zeros}
amm_read_o  out  1  AMM read
amm_write_o  out  1  AMM write
amm_burstcount_o  out  AMM_BURST_W  AMM burstcount
amm_byteenable_o  out  BYTE_PER_WORD  AMM byteenable
amm_writedata_o  out  AMM_DATA_W  equals wr_data_i
amm_waitrequest_i  in  1  AMM waitrequest
amm_readdatavalid_i  in  1  AMM read data valid
rd_pend_o  out  $clog2(MAX_RD_WORDS+1)  read words outstanding
busy_o  out  1  state != IDLE or rd_pend_o != 0

Behaviour:
- Reset values: op_ready_o, amm_read_o, amm_write_o, wr_data_req_o, busy_o, rd_pend_o = 0. amm_address_o, amm_burstcount_o, amm_byteenable_o = 0. FSM = IDLE.
- op_ready_o is registered. It is 1 in IDLE from the first cycle after reset release. It falls the cycle after a handshake.
- Handshake (op_valid_i && op_ready_o): capture all op_* fields. Burst = max(op_burst_i, 1). Load amm_address_o and amm_burstcount_o; both stay constant for the whole burst.
- FSM:
  - IDLE: on write handshake go to WR; on read handshake go to RD.
  - WR: amm_write_o = 1 every cycle. A beat is accepted when amm_write_o && !amm_waitrequest_i. wr_data_req_o = that accept, combinational. The beat counter increments per accepted beat. On the last accepted beat go to IDLE; amm_write_o = 0 next cycle.
  - RD: amm_read_o rises only when rd_pend_o + burst <= MAX_RD_WORDS, evaluated with the current-cycle readdatavalid decrement. Once high, amm_read_o holds until !amm_waitrequest_i, then the FSM goes to IDLE.
- Byteenable per beat:
  - first beat: bits [BYTE_PER_WORD-1 : start_off] set.
  - last beat: bits [end_off : 0] set.
  - single-beat burst: the AND of the two masks.
  - middle beats: all ones.
  - A single-beat burst with end_off < start_off is illegal input; byteenable = 0 and the beat is still issued.
- rd_pend: adds burst on read accept and subtracts 1 per amm_readdatavalid_i. When both happen in the same cycle the net change is applied. Saturates at 0; readdatavalid with rd_pend = 0 is ignored.
- All AMM outputs hold stable while waitrequest is asserted.
- Reset mid-burst: the next cycle has amm_read_o = amm_write_o = 0 and rd_pend_o = 0. The FSM is in IDLE and outstanding read data is discarded by the upstream logic.

Optional Feature:
AMM_SCHED_STATS_EN
- Defined: adds stats_clr_i (in, 1), wr_burst_cnt_o (out, 32) and rd_burst_cnt_o (out, 32).
  - Each counter increments on the accepted command of its type: last write beat, or read accept.
  - Counters wrap at 2^32.
  - stats_clr_i zeros both counters and has priority over an increment in the same cycle.
  - Reset value of both counters is 0.
- Undefined: these ports and counters do not exist.

Test Plan:
- Write, word addr 0x1, burst 1, start 3, end 9 -> one beat; amm_address_o = 0x010, burstcount 1, byteenable 0x03F8, one wr_data_req_o pulse.
- Write, burst 3, start 4, end 2 -> byteenable 0xFFF0, 0xFFFF, 0x0007; address and burstcount 3 held for all beats; op_ready_o returns to 1 one cycle after the last beat.
- Same write with waitrequest high for 5 cycles on beat 2 -> outputs stable during the stall; exactly 3 wr_data_req_o pulses; 8 cycles of amm_write_o total.
- Reads of burst 8, 8, then 4 with no readdatavalid -> first two issue and rd_pend_o = 16. The third keeps amm_read_o = 0 until 4 readdatavalid pulses return; it rises the cycle rd_pend_o reaches 12 and leaves rd_pend_o = 16 after acceptance.
- Read accept and readdatavalid in the same cycle with rd_pend_o = 5 and burst 2 -> rd_pend_o = 6.
- rst_i pulsed on beat 2 of a 4-beat write -> next cycle amm_write_o = 0, rd_pend_o = 0, op_ready_o = 1 one cycle after release. With AMM_SCHED_STATS_EN defined, also check counters after 3 writes and 2 reads = 3 and 2, and stats_clr_i together with an increment -> 0.
